// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_if.sv
// Bundle of the FIFO-side handshake and serial-side status signals of uart_tx.
// master = transmitter side, slave = FIFO/host side.
interface uart_tx_if #(
  parameter int unsigned DATA_SIZE = 8
);

  logic                 tx_en;
  logic [DATA_SIZE-1:0] fifo_data;
  logic                 fifo_empty;
  logic                 fifo_read;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;

  modport master (
    input  tx_en, fifo_data, fifo_empty,
    output fifo_read, tx, busy, tx_done
  );

  modport slave (
    output tx_en, fifo_data, fifo_empty,
    input  fifo_read, tx, busy, tx_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period divider: tick is high on the last clk cycle of every CLK_DIV-cycle period.
// clear holds the count at zero so a period starts aligned to the cycle after clear drops.
module uart_baud_gen #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed from a TX FIFO: pops one word per frame, sends start/data/stop.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic [DATA_SIZE-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned BW = 4;

  uart_tx_state_e       state_q, state_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 tick, baud_clear;
  logic                 last_data, last_stop;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (tick)
  );

  assign last_data = (bit_cnt_q == BW'(DATA_SIZE - 1));
  assign last_stop = (bit_cnt_q == BW'(STOP_BITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // bit_cnt_q counts data bits in DATA and stop bits in STOP
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE:  if (tx_en && !fifo_empty) state_d = FETCH;
      FETCH: begin
        shift_d   = fifo_data;
        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
        parity_d  = (^fifo_data) ^ 1'(PARITY_ODD);
`endif
        state_d   = START;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        if (last_data) begin
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d   = PARITY;
`else
          state_d   = STOP;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) begin
        if (last_stop) state_d   = IDLE;
        else           bit_cnt_d = bit_cnt_q + BW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // reset gates the pop strobe so a held reset cannot drain the FIFO
  always_comb begin
    tx         = UART_IDLE_LEVEL;
    busy       = (state_q != IDLE);
    fifo_read  = 1'b0;
    tx_done    = 1'b0;
    baud_clear = 1'b0;
    case (state_q)
      IDLE: begin
        fifo_read  = tx_en & ~fifo_empty & ~reset;
        baud_clear = 1'b1;
      end
      FETCH:  baud_clear = 1'b1;
      START:  tx = UART_START_LEVEL;
      DATA:   tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = parity_q;
`endif
      STOP:   tx_done = tick & last_stop;
      default: ;
    endcase
  end

endmodule
